gty_quad_reset_sequencer: RTL and testbench
===========================================

GTY_QUAD_RESET_SEQUENCER -- requirements
Module: gty_quad_reset_sequencer

Interface
REQ-001 SHALL provide parameter NUM_QUADS, default 2, number of GTY quads sequenced.
REQ-002 SHALL provide parameter CH_PER_QUAD, default 4, channels per quad.
REQ-003 SHALL provide parameter RESET_PULSE, default 16, reset pulse width in clk cycles.
REQ-004 SHALL provide parameter TIMEOUT_CYCLES, default 1000000, wait limit per phase in clk cycles.
REQ-005 SHALL have port clk, input, 1: free-running system clock, the same clock that drives the IBERT core.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start_i, input, 1: single-cycle request to run the full bring-up.
REQ-008 SHALL have port qpll_lock_i, input, NUM_QUADS: per-quad QPLL lock, asynchronous to clk.
REQ-009 SHALL have port tx_resetdone_i, input, NUM_QUADS*CH_PER_QUAD: per-channel TX reset done, asynchronous.
REQ-010 SHALL have port rx_resetdone_i, input, NUM_QUADS*CH_PER_QUAD: per-channel RX reset done, asynchronous.
REQ-011 SHALL have port qpll_reset_o, output, NUM_QUADS: per-quad QPLL reset.
REQ-012 SHALL have port gttxreset_o, output, NUM_QUADS: per-quad TX reset, applied to all channels of the quad.
REQ-013 SHALL have port gtrxreset_o, output, NUM_QUADS: per-quad RX reset.
REQ-014 SHALL have ports busy_o, done_o and fail_o, output, 1 each: sequence status.
REQ-015 SHALL have port fail_quad_o, output, NUM_QUADS: sticky per-quad failure flags.

Function
REQ-016 SHALL pass all status inputs (lock, tx/rx resetdone) through 2-flop synchronisers before any use, adding 2 cycles of latency.
REQ-017 SHALL implement the states IDLE, PLL_RST, PLL_WAIT, TX_RST, TX_WAIT, RX_RST, RX_WAIT, NEXT and DONE.
REQ-018 SHALL process quads serially in the order 0..NUM_QUADS-1 using one shared quad index and one shared cycle counter.
REQ-019 SHALL move from IDLE or DONE to PLL_RST with quad index 0 on the clk edge at which start_i=1; start_i SHALL be ignored in every other state.
REQ-020 SHALL, in each *_RST state, hold the matching reset high for the current quad only, for exactly RESET_PULSE cycles, then enter the matching *_WAIT state.
REQ-021 SHALL leave PLL_WAIT for TX_RST once the synchronised lock of the current quad is 1.
REQ-022 SHALL leave TX_WAIT for RX_RST, and RX_WAIT for NEXT, once all CH_PER_QUAD synchronised done bits of the current quad are 1.
REQ-023 SHALL, in each *_WAIT state, declare a timeout when the counter reaches TIMEOUT_CYCLES-1 while the condition is still false; the counter SHALL clear on every state change.
REQ-024 SHALL, on a final timeout, set fail_quad_o[index] and enter NEXT; the remaining quads SHALL still be sequenced.
REQ-025 SHALL, in NEXT, increment the quad index and enter PLL_RST, or enter DONE after the last quad.
REQ-026 SHALL hold busy_o=1 in every state except IDLE and DONE.
REQ-027 SHALL drive done_o=1 in DONE; fail_o SHALL equal the OR of fail_quad_o while in DONE, and 0 otherwise.
REQ-028 SHALL, in DONE, clear done_o and set fail_quad_o[q] when the synchronised lock of a quad q that passed drops to 0; no automatic re-sequencing SHALL occur.
REQ-029 SHALL clear fail_quad_o only on reset or on an accepted start_i.
REQ-030 SHALL keep the counter and index widths sufficient for TIMEOUT_CYCLES and NUM_QUADS, with no wrap before a terminal count.

Reset
REQ-031 SHALL, while rst_n=0, assert all qpll_reset_o, gttxreset_o and gtrxreset_o to 1, set the state to IDLE, clear the synchronisers, counter and index, and drive busy_o, done_o, fail_o and fail_quad_o to 0.
REQ-032 SHALL, on rst_n release, deassert all reset outputs on the first clk edge, sit in IDLE, and require start_i to begin a sequence.
REQ-033 SHALL, when rst_n is asserted mid-sequence, abort immediately with outputs as in REQ-031.

Configuration
REQ-034 SHALL support the macro GTY_SEQ_RETRY_EN.
REQ-035 SHALL, with GTY_SEQ_RETRY_EN defined, return a timeout in any *_WAIT state to PLL_RST for the same quad up to 3 times (per-quad 2-bit retry counter, cleared on NEXT); only the 4th timeout is final.
REQ-036 SHALL, without GTY_SEQ_RETRY_EN, make the first timeout final and synthesise no retry counter.

Verification
REQ-037 SHALL verify the nominal case: RESET_PULSE=16, TIMEOUT_CYCLES=1000, all lock and done inputs tied 1, start_i pulsed -> qpll_reset_o[0] high for 16 cycles, then TX and RX pulses, then quad 1, then done_o=1 and fail_o=0.
REQ-038 SHALL verify a missing lock: qpll_lock_i[1]=0 throughout, retry disabled -> quad 1 PLL_WAIT lasts 1000 cycles, fail_quad_o=2'b10, fail_o=1, done_o=1.
REQ-039 SHALL verify retry: GTY_SEQ_RETRY_EN defined, tx_resetdone_i[2]=0 until the 2nd retry -> exactly 3 qpll_reset_o[0] pulses, fail_quad_o=0.
REQ-040 SHALL verify lock loss: in DONE, qpll_lock_i[0] falls -> done_o=0 and fail_quad_o[0]=1 within 3 cycles.
REQ-041 SHALL verify reset mid-operation: rst_n=0 during TX_WAIT of quad 0 -> all reset outputs=1 and busy_o=0 asynchronously; after release, start_i restarts from quad 0.
REQ-042 SHALL verify start_i ignored while busy: start_i pulsed during RX_RST -> sequence timing unchanged.

Source files
------------

// File: rtl/gty_quad_reset_sequencer.sv
// Serial QPLL -> TX -> RX reset bring-up for NUM_QUADS GTY quads with per-phase timeouts.
// Optional: define GTY_SEQ_RETRY_EN to retry a timed-out quad up to three times before flagging it.
module gty_quad_reset_sequencer #(
    parameter int NUM_QUADS      = 2,
    parameter int CH_PER_QUAD    = 4,
    parameter int RESET_PULSE    = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    input  logic [NUM_QUADS-1:0]             qpll_lock_i,
    input  logic [NUM_QUADS*CH_PER_QUAD-1:0] tx_resetdone_i,
    input  logic [NUM_QUADS*CH_PER_QUAD-1:0] rx_resetdone_i,
    output logic [NUM_QUADS-1:0]             qpll_reset_o,
    output logic [NUM_QUADS-1:0]             gttxreset_o,
    output logic [NUM_QUADS-1:0]             gtrxreset_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             fail_o,
    output logic [NUM_QUADS-1:0]             fail_quad_o
);

    localparam int NCH     = NUM_QUADS * CH_PER_QUAD;
    localparam int IDX_W   = (NUM_QUADS > 1) ? $clog2(NUM_QUADS) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > RESET_PULSE) ? TIMEOUT_CYCLES : RESET_PULSE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_QUADS - 1);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(RESET_PULSE - 1);
    localparam logic [CNT_W-1:0] WAIT_END  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, PLL_RST, PLL_WAIT, TX_RST, TX_WAIT, RX_RST, RX_WAIT, NEXT, DONE
    } state_t;

    state_t               state, next_state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx, next_idx;
    logic [NUM_QUADS-1:0] next_sel, fail_set;
    logic                 start_acc, done_set, done_clr, timeout, retry_ok;
    logic                 counting, pulse_end, wait_end;

    logic [NUM_QUADS-1:0] lock_meta, lock_sync;
    logic [NCH-1:0]       tx_meta, tx_sync, rx_meta, rx_sync;
    logic [NUM_QUADS-1:0] tx_ready, rx_ready;

    // NOTE: every clocked process uses <= so all flops sample pre-edge values, as hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= '0;
            lock_sync <= '0;
            tx_meta   <= '0;
            tx_sync   <= '0;
            rx_meta   <= '0;
            rx_sync   <= '0;
        end else begin
            lock_meta <= qpll_lock_i;
            lock_sync <= lock_meta;
            tx_meta   <= tx_resetdone_i;
            tx_sync   <= tx_meta;
            rx_meta   <= rx_resetdone_i;
            rx_sync   <= rx_meta;
        end
    end

    always_comb begin
        for (int q = 0; q < NUM_QUADS; q++) begin
            tx_ready[q] = &tx_sync[q*CH_PER_QUAD +: CH_PER_QUAD];
            rx_ready[q] = &rx_sync[q*CH_PER_QUAD +: CH_PER_QUAD];
        end
    end

`ifdef GTY_SEQ_RETRY_EN
    logic [1:0] retry_cnt;

    assign retry_ok = (retry_cnt != 2'd3);

    // Shared by all quads: quads run serially and the count restarts on NEXT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retry_cnt <= '0;
        else if (start_acc || state == NEXT)
            retry_cnt <= '0;
        else if (timeout && retry_ok)
            retry_cnt <= retry_cnt + 1'b1;
    end
`else
    assign retry_ok = 1'b0;
`endif

    assign counting  = state inside {PLL_RST, PLL_WAIT, TX_RST, TX_WAIT, RX_RST, RX_WAIT};
    assign pulse_end = (cnt == PULSE_END);
    assign wait_end  = (cnt == WAIT_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        next_state = state;
        next_idx   = idx;
        fail_set   = '0;
        start_acc  = 1'b0;
        done_set   = 1'b0;
        done_clr   = 1'b0;
        timeout    = 1'b0;

        unique case (state)
            IDLE: if (start_i) begin
                next_state = PLL_RST;
                next_idx   = '0;
                start_acc  = 1'b1;
            end
            PLL_RST:  if (pulse_end) next_state = PLL_WAIT;
            PLL_WAIT: if (lock_sync[idx]) next_state = TX_RST;
                      else if (wait_end)  timeout = 1'b1;
            TX_RST:   if (pulse_end) next_state = TX_WAIT;
            TX_WAIT:  if (tx_ready[idx]) next_state = RX_RST;
                      else if (wait_end) timeout = 1'b1;
            RX_RST:   if (pulse_end) next_state = RX_WAIT;
            RX_WAIT:  if (rx_ready[idx]) next_state = NEXT;
                      else if (wait_end) timeout = 1'b1;
            NEXT: if (idx == LAST_IDX) begin
                next_state = DONE;
                done_set   = 1'b1;
            end else begin
                next_state = PLL_RST;
                next_idx   = idx + 1'b1;
            end
            DONE: if (start_i) begin
                next_state = PLL_RST;
                next_idx   = '0;
                start_acc  = 1'b1;
            end else begin
                // A quad that came up cleanly but has since lost lock is flagged; no re-run.
                fail_set = ~lock_sync & ~fail_quad_o;
                done_clr = |fail_set;
            end
            default: next_state = IDLE;
        endcase

        if (timeout) begin
            if (retry_ok) begin
                next_state = PLL_RST;
            end else begin
                next_state    = NEXT;
                fail_set[idx] = 1'b1;
            end
        end

        next_sel = NUM_QUADS'(1) << next_idx;
    end

    // Reset outputs are decoded from the next state so they line up exactly with the *_RST states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            idx          <= '0;
            fail_quad_o  <= '0;
            done_o       <= 1'b0;
            qpll_reset_o <= '1;
            gttxreset_o  <= '1;
            gtrxreset_o  <= '1;
        end else begin
            if (next_state != state) cnt <= '0;
            else if (counting)       cnt <= cnt + 1'b1;

            idx <= next_idx;

            if (start_acc) fail_quad_o <= '0;
            else           fail_quad_o <= fail_quad_o | fail_set;

            if (done_set)                   done_o <= 1'b1;
            else if (start_acc || done_clr) done_o <= 1'b0;

            qpll_reset_o <= (next_state == PLL_RST) ? next_sel : '0;
            gttxreset_o  <= (next_state == TX_RST)  ? next_sel : '0;
            gtrxreset_o  <= (next_state == RX_RST)  ? next_sel : '0;
        end
    end

    assign busy_o = !(state inside {IDLE, DONE});
    assign fail_o = (state == DONE) && (|fail_quad_o);

endmodule

// File: tb/tb_gty_quad_reset_sequencer.sv
// Scoreboard bench for gty_quad_reset_sequencer: a cycle model predicts every reset pulse and the
// DONE cycle; a negedge monitor pops and compares each pulse as it completes. Works with or without GTY_SEQ_RETRY_EN.
module tb_gty_quad_reset_sequencer;

    localparam int NQ    = 2;
    localparam int CPQ   = 4;
    localparam int PULSE = 16;
    localparam int TO    = 1000;
`ifdef GTY_SEQ_RETRY_EN
    localparam int RETRIES = 3;
`else
    localparam int RETRIES = 0;
`endif

    typedef struct {
        int kind;   // 0 qpll, 1 tx, 2 rx
        int quad;
        int rise;
        int width;
    } pulse_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [NQ-1:0]     qpll_lock_i;
    logic [NQ*CPQ-1:0] tx_resetdone_i;
    logic [NQ*CPQ-1:0] rx_resetdone_i;
    logic [NQ-1:0]     qpll_reset_o, gttxreset_o, gtrxreset_o;
    logic              busy_o, done_o, fail_o;
    logic [NQ-1:0]     fail_quad_o;

    gty_quad_reset_sequencer #(
        .NUM_QUADS(NQ), .CH_PER_QUAD(CPQ), .RESET_PULSE(PULSE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .qpll_lock_i(qpll_lock_i), .tx_resetdone_i(tx_resetdone_i), .rx_resetdone_i(rx_resetdone_i),
        .qpll_reset_o(qpll_reset_o), .gttxreset_o(gttxreset_o), .gtrxreset_o(gtrxreset_o),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .fail_quad_o(fail_quad_o)
    );

    always #5 clk = ~clk;

    int       cyc = 0;
    int       n_checks = 0;
    int       n_pass = 0;
    int       done_rise = -1;
    bit       mon_en = 1'b0;
    pulse_t   sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic push_pulse(input int kind, input int quad, input int rise);
        pulse_t p;
        p.kind  = kind;
        p.quad  = quad;
        p.rise  = rise;
        p.width = PULSE;
        sb.push_back(p);
    endtask

    task automatic score(input int kind, input int quad, input int rise, input int width);
        pulse_t e;
        if (sb.size() == 0) begin
            check("unexpected_pulse", kind*10 + quad, -1);
        end else begin
            e = sb.pop_front();
            check("pulse_id", kind*10 + quad, e.kind*10 + e.quad);
            check("pulse_rise", rise, e.rise);
            check("pulse_width", width, e.width);
        end
    endtask

    // Monitor: pulses sampled on the falling edge, timestamped with the rising-edge count.
    logic [3*NQ-1:0] prev_v = '0;
    logic            done_prev = 1'b0;
    int              rise_at [3*NQ];

    always @(negedge clk) begin
        logic [3*NQ-1:0] cur_v;
        cur_v = {gtrxreset_o, gttxreset_o, qpll_reset_o};
        for (int b = 0; b < 3*NQ; b++) begin
            if (mon_en && cur_v[b] && !prev_v[b]) rise_at[b] = cyc;
            if (mon_en && !cur_v[b] && prev_v[b]) score(b / NQ, b % NQ, rise_at[b], cyc - rise_at[b]);
        end
        prev_v = cur_v;
        if (mon_en && done_o && !done_prev && done_rise < 0) done_rise = cyc;
        done_prev = done_o;
    end

    // Cycle model. t is the edge at which the quad's PLL_RST begins; returns the DONE edge.
    task automatic model_run(input int t0, input bit [NQ-1:0] lock_ok, input int tx_to_q0,
                             output int t_done, output logic [NQ-1:0] fails);
        int t;
        t     = t0;
        fails = '0;
        for (int q = 0; q < NQ; q++) begin
            int attempt;
            int tx_left;
            bit fin;
            attempt = 0;
            tx_left = (q == 0) ? tx_to_q0 : 0;
            fin     = 1'b0;
            while (!fin) begin
                push_pulse(0, q, t);
                if (!lock_ok[q]) begin
                    t += PULSE + TO;
                    if (attempt < RETRIES) attempt++;
                    else begin fails[q] = 1'b1; t += 1; fin = 1'b1; end
                end else begin
                    push_pulse(1, q, t + PULSE + 1);
                    if (tx_left > 0) begin
                        tx_left--;
                        t += 2*PULSE + 1 + TO;
                        if (attempt < RETRIES) attempt++;
                        else begin fails[q] = 1'b1; t += 1; fin = 1'b1; end
                    end else begin
                        push_pulse(2, q, t + 2*PULSE + 2);
                        t += 3*PULSE + 4;
                        fin = 1'b1;
                    end
                end
            end
        end
        t_done = t;
    endtask

    task automatic run_start(output int t0);
        @(negedge clk);
        start_i   = 1'b1;
        done_rise = -1;
        t0        = cyc + 1;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_done(input int t_exp, input logic [NQ-1:0] f_exp);
        int n;
        n = 0;
        while (done_rise < 0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("done_cycle", done_rise, t_exp);
        check("done_level", int'(done_o), 1);
        check("busy_in_done", int'(busy_o), 0);
        check("fail_quad", int'(fail_quad_o), int'(f_exp));
        check("fail_or", int'(fail_o), int'(|f_exp));
        check("sb_drain", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0, t_exp;
        logic [NQ-1:0] f_exp;

        rst_n          = 1'b0;
        start_i        = 1'b0;
        qpll_lock_i    = '1;
        tx_resetdone_i = '1;
        rx_resetdone_i = '1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_qpll", int'(qpll_reset_o), 3);
        check("rst_tx", int'(gttxreset_o), 3);
        check("rst_rx", int'(gtrxreset_o), 3);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_fail", int'(fail_o), 0);
        check("rst_fail_quad", int'(fail_quad_o), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_qpll", int'(qpll_reset_o), 0);
        check("rel_tx", int'(gttxreset_o), 0);
        check("rel_rx", int'(gtrxreset_o), 0);
        repeat (5) @(negedge clk);
        check("idle_busy", int'(busy_o), 0);
        mon_en = 1'b1;

        // Nominal bring-up
        run_start(t0);
        model_run(t0, 2'b11, 0, t_exp, f_exp);
        wait_cyc(t0 + 5);
        check("nom_busy", int'(busy_o), 1);
        check("nom_fail_mid", int'(fail_o), 0);
        wait_done(t_exp, f_exp);

        // Restart from DONE with a stray start during RX_RST of quad 0
        run_start(t0);
        model_run(t0, 2'b11, 0, t_exp, f_exp);
        wait_cyc(t0 + 40);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(t_exp, f_exp);

        // Lock loss while in DONE
        qpll_lock_i[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("loss_done", int'(done_o), 0);
        check("loss_fail_quad", int'(fail_quad_o), 1);
        check("loss_fail", int'(fail_o), 1);
        check("loss_busy", int'(busy_o), 0);
        qpll_lock_i[0] = 1'b1;
        repeat (4) @(negedge clk);

        // Quad 1 never locks
        qpll_lock_i[1] = 1'b0;
        repeat (4) @(negedge clk);
        run_start(t0);
        model_run(t0, 2'b01, 0, t_exp, f_exp);
        wait_cyc(t0 + 2);
        check("start_clears_fail", int'(fail_quad_o), 0);
        wait_done(t_exp, f_exp);
        qpll_lock_i[1] = 1'b1;
        repeat (4) @(negedge clk);

        // TX done of quad 0 channel 2 stuck low until the second retry is under way
        tx_resetdone_i[2] = 1'b0;
        repeat (4) @(negedge clk);
        run_start(t0);
        model_run(t0, 2'b11, 2, t_exp, f_exp);
        wait_cyc(t0 + 1040);
        check("tx_mid_busy", int'(busy_o), 1);
        check("tx_mid_fail", int'(fail_o), 0);
        wait_cyc(t0 + 2070);
        tx_resetdone_i[2] = 1'b1;
        wait_done(t_exp, f_exp);

        // Reset during TX_WAIT of quad 0, then a clean restart
        tx_resetdone_i[0] = 1'b0;
        repeat (4) @(negedge clk);
        run_start(t0);
        push_pulse(0, 0, t0);
        push_pulse(1, 0, t0 + PULSE + 1);
        wait_cyc(t0 + 40);
        check("pre_rst_busy", int'(busy_o), 1);
        check("pre_rst_drain", sb.size(), 0);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("abort_qpll", int'(qpll_reset_o), 3);
        check("abort_tx", int'(gttxreset_o), 3);
        check("abort_rx", int'(gtrxreset_o), 3);
        check("abort_busy", int'(busy_o), 0);
        check("abort_done", int'(done_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx_resetdone_i[0] = 1'b1;
        @(posedge clk);
        #1;
        check("rerel_qpll", int'(qpll_reset_o), 0);
        check("rerel_busy", int'(busy_o), 0);
        repeat (5) @(negedge clk);
        mon_en = 1'b1;
        run_start(t0);
        model_run(t0, 2'b11, 0, t_exp, f_exp);
        wait_done(t_exp, f_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
